multi_timer: RTL
================

# multi_timer

Parametrised multi-channel countdown timer. A single free-running prescaler derives a shared tick from `clk_104mhz`. Each of `NUM_CH` independent channels loads a `CNT_W`-bit count and decrements it once per tick. Channels support one-shot or periodic auto-reload, pause/resume, and retrigger. It serves game-round, debounce-timeout and display-blink timing wherever several countdowns must run at once on the same time base.

## Interface
- `NUM_CH`, 4, number of independent channels
- `CNT_W`, 8, width of each channel's count
- `TICK_DIV`, 52_000_000, clock cycles per tick (≥2); prescaler width is `$clog2(TICK_DIV)`
- `clk_104mhz`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  NUM_CH  per-channel load/retrigger pulse
- `pause`  in  NUM_CH  per-channel level; high freezes the channel
- `periodic`  in  NUM_CH  mode, sampled on `start`: 1 = auto-reload, 0 = one-shot
- `value`  in  NUM_CH*CNT_W  load value; channel i at `[i*CNT_W +: CNT_W]`
- `expired`  out  NUM_CH  one-cycle pulse per channel on reaching zero
- `running`  out  NUM_CH  channel in RUN or HOLD
- `countdown_out`  out  NUM_CH*CNT_W  current count per channel, same packing as `value`
- `tick`  out  1  shared prescaler tick, high one cycle per period

## Operation
- Prescaler:
  - Free-running from reset, counts 0..`TICK_DIV`-1 and wraps.
  - `tick` = (prescaler == `TICK_DIV`-1).
  - `start` never resets the prescaler. The first decrement after load therefore falls 1..`TICK_DIV` cycles later.
- Per-channel state machine has three states: IDLE, RUN, HOLD. Each channel holds a count register, a reload register and a mode bit.
- Priority per channel: `rst_n` low > `start` > `pause` > `tick`.
- Any state, `start[i]`:
  - Latch `value` into both count and reload; latch `periodic` into the mode bit.
  - If `value`==0: count stays 0, `expired[i]` pulses, next state IDLE. This holds in both modes.
  - Otherwise next state is RUN. `pause` and `tick` are ignored in the `start` cycle.
- RUN:
  - `pause[i]` high: go to HOLD; a coincident tick is ignored.
  - Else on `tick` with count > 1: decrement.
  - Else on `tick` with count == 1, one-shot: count <= 0, `expired` pulse, go to IDLE.
  - Else on `tick` with count == 1, periodic: count <= reload, `expired` pulse, stay in RUN.
- HOLD:
  - Count is frozen and ticks are ignored.
  - `pause[i]` low: return to RUN. A tick in that same cycle is also ignored.
- IDLE: count holds its value (0 after expiry). Ticks are ignored. `expired` stays low.
- `running[i]` = state is RUN or HOLD.
- Channels are fully independent. Simultaneous expiries on several channels all pulse in the same cycle.
- Arithmetic is unsigned `CNT_W`-bit. The count never decrements below 0 and never wraps.

## Timing
- Reset:
  - Prescaler = 0 and every channel is IDLE.
  - `expired`, `running`, `countdown_out` and `tick` are all 0.
  - Reset mid-count aborts silently: no `expired` pulse.
- All outputs except `tick` are registered.
- `start` in cycle n: `countdown_out` = value and `running` = 1 in cycle n+1.
- A zero-value `start` gives an `expired` pulse in cycle n+1.
- Decrement: a tick in cycle t updates `countdown_out` in cycle t+1.
- Expiry: `expired`=1, `countdown_out`=0 (or reload) and `running`=0 (one-shot) all appear together in cycle t+1, for exactly one cycle.
- Periodic channels have an exact period of `value`*`TICK_DIV` cycles after the first expiry.
- A `start` coinciding with a tick at count 1 is a retrigger: the channel reloads and no `expired` pulse occurs.

## Test plan
All scenarios use `NUM_CH`=2, `CNT_W`=4, `TICK_DIV`=4.
- Reset: hold `rst_n` low 3 cycles with `start`=2'b11 -> all outputs 0 throughout. `tick` first rises 4 cycles after release.
- One-shot: ch0 `start` with value=3, issued the cycle after `tick` -> `countdown_out` follows 3,2,1,0. `expired[0]` is one cycle high, 12 cycles after load, with `running[0]` falling the same cycle.
- Periodic: ch1 value=2, periodic=1 -> count follows 2,1,2,1… `expired[1]` pulses every 8 cycles and `running[1]` stays 1.
- Pause: ch0 value=5 with `pause` high across exactly 2 ticks -> count frozen. Expiry is delayed by 8 cycles versus the unpaused run, and `running` stays 1.
- Edge cases:
  - `start` with value=0 -> `expired` pulses next cycle and `running` stays 0.
  - Retrigger with value=4 in a tick cycle at count 1 -> no `expired`, and the count shows 4.
- Concurrency: both channels loaded with value=2 on the same cycle -> `expired`=2'b11 in one cycle, with no cross-channel interference.

Source files
------------

// File: rtl/multi_timer.sv
// ============================================================================
// Module      : multi_timer
// Description : Multi-channel countdown timer on a shared prescaler tick,
//               with one-shot/periodic modes, pause and retrigger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_timer #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 52_000_000
) (
    input  logic                    clk_104mhz,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] value,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH*CNT_W-1:0] countdown_out,
    output logic                    tick
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] c_presc_one = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [PRESC_W-1:0] r_presc;

    // Free-running; channel starts never disturb the shared time base.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_presc == c_presc_max) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_presc_one;
        end
    end

    assign tick = (r_presc == c_presc_max);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] w_count_nxt;
        logic [CNT_W-1:0] r_reload;
        logic [CNT_W-1:0] w_reload_nxt;
        logic [CNT_W-1:0] w_value;
        logic             r_mode;
        logic             w_mode_nxt;
        logic             r_expired;
        logic             w_expired_nxt;
        logic             r_running;

        assign w_value = value[i*CNT_W +: CNT_W];

        always_comb begin
            w_state_nxt   = r_state;
            w_count_nxt   = r_count;
            w_reload_nxt  = r_reload;
            w_mode_nxt    = r_mode;
            w_expired_nxt = 1'b0;
            if (start[i]) begin
                w_count_nxt  = w_value;
                w_reload_nxt = w_value;
                w_mode_nxt   = periodic[i];
                if (w_value == '0) begin
                    w_expired_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt   = ST_RUN;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (pause[i]) begin
                            w_state_nxt = ST_HOLD;
                        end else if (tick) begin
                            if (r_count > c_cnt_one) begin
                                w_count_nxt = r_count - c_cnt_one;
                            end else if (r_count == c_cnt_one) begin
                                w_expired_nxt = 1'b1;
                                if (r_mode) begin
                                    w_count_nxt = r_reload;
                                end else begin
                                    w_count_nxt = '0;
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                        end
                    end
                    // Resume costs the tick of the release cycle.
                    ST_HOLD: begin
                        if (!pause[i]) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_104mhz) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_count   <= '0;
                r_reload  <= '0;
                r_mode    <= 1'b0;
                r_expired <= 1'b0;
                r_running <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_count   <= w_count_nxt;
                r_reload  <= w_reload_nxt;
                r_mode    <= w_mode_nxt;
                r_expired <= w_expired_nxt;
                r_running <= (w_state_nxt != ST_IDLE);
            end
        end

        assign expired[i]                        = r_expired;
        assign running[i]                        = r_running;
        assign countdown_out[i*CNT_W +: CNT_W]   = r_count;
    end

endmodule

`default_nettype wire
